// File: rtl/piso_serial_tx_if.sv
// Word-in / bit-out bus for piso_serial_tx: upstream valid/ready handshake plus the
// serial line, its qualifier and the end-of-frame pulse.
interface piso_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d_par;
    logic             in_valid;
    logic             in_ready;
    logic             q;
    logic             q_valid;
    logic             done;

    modport master (
        output d_par, in_valid,
        input  in_ready, q, q_valid, done
    );

    modport slave (
        input  d_par, in_valid,
        output in_ready, q, q_valid, done
    );
endinterface

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word per handshake, one bit per clk.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              r_n,
    piso_serial_tx_if.slave   bus
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             q_q, q_d;
    logic             qv_q, qv_d;
    logic             done_q, done_d;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    // Bit that leaves first from a word, and the word left after it is gone.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

`ifdef PISO_PARITY_EN
    assign bus.in_ready = (state_q == IDLE) || (state_q == PARITY);
`else
    assign bus.in_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0));
`endif

    assign accept      = bus.in_valid && bus.in_ready;
    assign bus.q       = q_q;
    assign bus.q_valid = qv_q;
    assign bus.done    = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        q_d     = 1'b0;
        qv_d    = 1'b0;
        done_d  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: ;
            SHIFT: begin
                if (cnt_q != '0) begin
                    q_d   = head(sh_q);
                    sh_d  = adv(sh_q);
                    cnt_d = cnt_q - CNT_ONE;
                    qv_d  = 1'b1;
`ifndef PISO_PARITY_EN
                    done_d = (cnt_q == CNT_ONE);
`endif
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
                    q_d     = par_q;
                    qv_d    = 1'b1;
                    done_d  = 1'b1;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // A handshake only ever lands where in_ready is high, i.e. at a frame
        // boundary, so it cleanly overrides whatever the case above chose.
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = CNT_LAST;
            q_d     = head(bus.d_par);
            sh_d    = adv(bus.d_par);
            qv_d    = 1'b1;
            done_d  = 1'b0;
`ifdef PISO_PARITY_EN
            par_d   = ^bus.d_par;
`endif
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            q_q     <= 1'b0;
            qv_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: MSB-first and LSB-first instances share one stimulus stream;
// a per-instance queue of expected {bit, done} pairs is filled at each accepted word.
module tb_piso_serial_tx;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk;
    logic         r_n;
    logic [W-1:0] d_par;
    logic         in_valid;
    int           errs   = 0;
    int           checks = 0;

    bit [1:0] expq [2][$];

    piso_serial_tx_if #(.WIDTH(W)) if0 ();
    piso_serial_tx_if #(.WIDTH(W)) if1 ();

    assign if0.d_par    = d_par;
    assign if0.in_valid = in_valid;
    assign if1.d_par    = d_par;
    assign if1.in_valid = in_valid;

    piso_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .r_n(r_n), .bus(if0));
    piso_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .r_n(r_n), .bus(if1));

    logic [1:0] q_w, qv_w, dn_w, rdy_w;
    assign q_w   = {if1.q, if0.q};
    assign qv_w  = {if1.q_valid, if0.q_valid};
    assign dn_w  = {if1.done, if0.done};
    assign rdy_w = {if1.in_ready, if0.in_ready};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a frame is the data bits in wire order, done on the last bit,
    // or on an extra even-parity bit when parity is enabled.
    function automatic void push_frame(input logic [W-1:0] w);
        for (int id = 0; id < 2; id++) begin
            for (int i = 0; i < W; i++) begin
                bit b;
                b = (id == 1) ? w[i] : w[W-1-i];
                expq[id].push_back({b, (i == W-1) && !PAR});
            end
            if (PAR) expq[id].push_back({^w, 1'b1});
        end
    endfunction

    // Acceptance observer: sample handshake mid-low-phase, commit after the edge.
    initial begin
        logic         acc;
        logic [W-1:0] w;
        forever begin
            @(negedge clk);
            #2;
            acc = in_valid && rdy_w[0] && r_n;
            w   = d_par;
            @(posedge clk);
            #1;
            if (acc && r_n) push_frame(w);
        end
    end

    // Monitor: a non-empty queue means a frame bit is due this cycle.
    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) begin
            int n;
            n = expq[id].size();
            // Ready exactly while idle or on the frame's final cycle.
            chk($sformatf("in_ready[%0d]", id), 32'(rdy_w[id]), 32'(n <= 1));
            if (n > 0) begin
                bit [1:0] e;
                e = expq[id].pop_front();
                chk($sformatf("q_valid[%0d]", id), 32'(qv_w[id]), 32'd1);
                chk($sformatf("q[%0d]", id), 32'(q_w[id]), 32'(e[1]));
                chk($sformatf("done[%0d]", id), 32'(dn_w[id]), 32'(e[0]));
            end else begin
                chk($sformatf("idle_q_valid[%0d]", id), 32'(qv_w[id]), 32'd0);
                chk($sformatf("idle_q[%0d]", id), 32'(q_w[id]), 32'd0);
                chk($sformatf("idle_done[%0d]", id), 32'(dn_w[id]), 32'd0);
            end
        end
    end

    task automatic async_reset_chk(input string nm);
        for (int id = 0; id < 2; id++) begin
            chk($sformatf("%s_q[%0d]", nm, id), 32'(q_w[id]), 32'd0);
            chk($sformatf("%s_q_valid[%0d]", nm, id), 32'(qv_w[id]), 32'd0);
            chk($sformatf("%s_done[%0d]", nm, id), 32'(dn_w[id]), 32'd0);
            chk($sformatf("%s_in_ready[%0d]", nm, id), 32'(rdy_w[id]), 32'd1);
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        bit ok;
        ok       = 1'b0;
        d_par    = w;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            #2;
            if (rdy_w[0]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit drained;
        r_n      = 1'b1;
        in_valid = 1'b0;
        d_par    = '0;
        #1 r_n = 1'b0;
        #2 async_reset_chk("reset");
        repeat (3) @(posedge clk);
        #3 r_n = 1'b1;
        #1;

        send(8'hA5);
        idle(12);

        send(8'hA5);
        send(8'h3C);
        idle(12);

        send(8'h01);
        d_par    = 8'hFF;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        idle(12);

        send(8'hFF);
        @(posedge clk);
        #2;
        r_n = 1'b0;
        expq[0].delete();
        expq[1].delete();
        #1 async_reset_chk("midframe_reset");
        repeat (2) @(posedge clk);
        #3 r_n = 1'b1;
        #1;
        send(8'h81);
        idle(12);

        send(8'h07);
        send(8'h03);
        idle(12);

        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            d_par    = W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        drained = 1'b0;
        for (int c = 0; c < 50 && !drained; c++) begin
            @(posedge clk);
            #1;
            if (expq[0].size() == 0 && expq[1].size() == 0) drained = 1'b1;
        end
        chk("drain_timeout", 32'(drained), 32'd1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
